// File: rtl/ahb_isp_job_ctrl_if.sv
// AHB-Lite slave-side bundle for the ISP job controller.
interface ahb_isp_job_ctrl_if;
    logic        HSEL;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HRDATA;
    logic        HREADYOUT;

    modport slave (
        input  HSEL, HWRITE, HREADY, HADDR, HWDATA, HTRANS, HSIZE,
        output HRDATA, HREADYOUT
    );
    modport master (
        output HSEL, HWRITE, HREADY, HADDR, HWDATA, HTRANS, HSIZE,
        input  HRDATA, HREADYOUT
    );
endinterface

// File: rtl/ahb_isp_job_ctrl.sv
// AHB-Lite register file with NUM_CH frame-buffer descriptors and a job FSM.
// Optional watchdog on the DRAIN phase is built when ISP_TIMEOUT_EN is defined.
module ahb_isp_job_ctrl #(
    parameter int NUM_CH = 4,
    parameter int DIM_W  = 12,
    parameter int ADDR_W = 32,
    parameter int TO_W   = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_isp_job_ctrl_if.slave     ahb,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic                  dp_dout_en,
    output logic [DIM_W-1:0]      cfg_h_active,
    output logic [DIM_W-1:0]      cfg_v_active,
    output logic [3:0]            cfg_bayer,
    output logic                  cfg_bypass,
    output logic [CH_W-1:0]       cfg_ch,
    output logic [ADDR_W-1:0]     fb_addr_out,
    output logic                  isp_int
);
    localparam int CNT_W = 2 * DIM_W;
    localparam logic [8:0] NCH9 = 9'(NUM_CH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
    state_t state, state_nxt;

    logic              acc_q, wr_q;
    logic [11:2]       addr_q;
    logic              bypass_r, irq_en, done, err, to_flag, to_hit;
    logic [3:0]        bayer_r;
    logic [CH_W-1:0]   ch_r, last_ch;
    logic [NUM_CH-1:0][DIM_W-1:0]  ch_h, ch_v;
    logic [NUM_CH-1:0][ADDR_W-1:0] ch_base;
    logic [CNT_W-1:0]  total, in_cnt, out_cnt, in_nxt, out_nxt;
    logic [ADDR_W-1:0] base_l;
    logic [DIM_W-1:0]  sel_h, sel_v;
    logic [ADDR_W-1:0] sel_base;
    logic              set_done, set_err, unused_bits;

    assign unused_bits = ^{ahb.HADDR[31:12], ahb.HADDR[1:0], ahb.HSIZE, ahb.HTRANS[0], ahb.HWDATA};

    // Address phase is registered; the write commits with HWDATA one cycle later.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            acc_q  <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
        end else begin
            acc_q  <= ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
            wr_q   <= ahb.HWRITE;
            addr_q <= ahb.HADDR[11:2];
        end
    end

    logic       wr_en, rd_en, is_ctrl, is_stat, is_cnt, ch_valid;
    logic [9:0] ch_word;
    assign wr_en    = acc_q & wr_q;
    assign rd_en    = acc_q & ~wr_q;
    assign is_ctrl  = (addr_q == 10'h000);
    assign is_stat  = (addr_q == 10'h001);
    assign is_cnt   = (addr_q == 10'h002);
    assign ch_word  = addr_q - 10'd4;
    assign ch_valid = (addr_q >= 10'd4) && (ch_word[9:1] < NCH9);

    logic start_pulse, abort_pulse, start_ok, start_bad, clr_done, clr_err, clr_to;
    assign start_pulse = wr_en & is_ctrl & ahb.HWDATA[0];
    assign abort_pulse = wr_en & is_ctrl & ahb.HWDATA[2];
    assign clr_done    = wr_en & is_stat & ahb.HWDATA[8];
    assign clr_err     = wr_en & is_stat & ahb.HWDATA[9];
    assign clr_to      = wr_en & is_stat & ahb.HWDATA[10];

    // Descriptor selected by the CH field of the same CTRL write that carries START.
    always_comb begin
        sel_h    = '0;
        sel_v    = '0;
        sel_base = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ahb.HWDATA[8 +: CH_W] == CH_W'(c)) begin
                sel_h    = ch_h[c];
                sel_v    = ch_v[c];
                sel_base = ch_base[c];
            end
        end
    end

    assign start_ok  = start_pulse && (state == IDLE) && (sel_h != '0) && (sel_v != '0);
    assign start_bad = start_pulse && (state == IDLE) && !((sel_h != '0) && (sel_v != '0));

    logic in_inc, out_inc, abort_evt;
    assign fifo_rd   = (state == RUN);
    assign in_inc    = fifo_rd & ~fifo_empty;
    assign out_inc   = dp_dout_en & (state != IDLE);
    assign in_nxt    = in_cnt + 1'b1;
    assign out_nxt   = out_cnt + 1'b1;
    assign abort_evt = (abort_pulse & (state != IDLE)) | to_hit;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Abort has priority over every completion path.
    always_comb begin
        state_nxt = state;
        set_done  = 1'b0;
        set_err   = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok)  state_nxt = RUN;
                if (start_bad) set_err   = 1'b1;
            end
            RUN: begin
                if (abort_evt) begin
                    state_nxt = IDLE;
                    set_err   = 1'b1;
                end else if (out_inc && out_nxt == total &&
                             (in_cnt == total || (in_inc && in_nxt == total))) begin
                    state_nxt = IDLE;
                    set_done  = 1'b1;
                end else if (in_inc && in_nxt == total) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_evt) begin
                    state_nxt = IDLE;
                    set_err   = 1'b1;
                end else if (out_inc && out_nxt == total) begin
                    state_nxt = IDLE;
                    set_done  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ISP_TIMEOUT_EN
    logic [TO_W-1:0] wd;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)                 wd <= '0;
        else if (start_ok | dp_dout_en) wd <= '0;
        else if (state == DRAIN)      wd <= wd + 1'b1;
    end
    assign to_hit = (state == DRAIN) && (&wd);
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) to_flag <= 1'b0;
        else          to_flag <= (to_flag & ~clr_to) | to_hit;
    end
`else
    logic [TO_W-1:0] to_unused;
    logic            clr_to_unused;
    assign to_unused     = '0;
    assign clr_to_unused = clr_to;
    assign to_hit        = 1'b0;
    assign to_flag       = 1'b0;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            bypass_r <= 1'b0;
            irq_en   <= 1'b0;
            bayer_r  <= '0;
            ch_r     <= '0;
            last_ch  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                ch_h[c]    <= DIM_W'(16);
                ch_v[c]    <= DIM_W'(16);
                ch_base[c] <= '0;
            end
            total        <= '0;
            in_cnt       <= '0;
            out_cnt      <= '0;
            base_l       <= '0;
            cfg_h_active <= '0;
            cfg_v_active <= '0;
            cfg_bayer    <= '0;
            cfg_bypass   <= 1'b0;
            cfg_ch       <= '0;
        end else begin
            if (wr_en && is_ctrl) begin
                bypass_r <= ahb.HWDATA[1];
                irq_en   <= ahb.HWDATA[3];
                bayer_r  <= ahb.HWDATA[7:4];
                ch_r     <= ahb.HWDATA[8 +: CH_W];
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_en && ch_valid && ch_word[9:1] == 9'(c)) begin
                    if (ch_word[0]) ch_base[c] <= ADDR_W'(ahb.HWDATA);
                    else begin
                        ch_h[c] <= ahb.HWDATA[DIM_W-1:0];
                        ch_v[c] <= ahb.HWDATA[16 +: DIM_W];
                    end
                end
            end
            done <= (done & ~clr_done) | set_done;
            err  <= (err & ~clr_err) | set_err;
            if (start_pulse && state == IDLE) last_ch <= ahb.HWDATA[8 +: CH_W];
            if (start_ok) begin
                total        <= CNT_W'(sel_h) * CNT_W'(sel_v);
                in_cnt       <= '0;
                out_cnt      <= '0;
                base_l       <= sel_base;
                cfg_h_active <= sel_h;
                cfg_v_active <= sel_v;
                cfg_bayer    <= ahb.HWDATA[7:4];
                cfg_bypass   <= ahb.HWDATA[1];
                cfg_ch       <= ahb.HWDATA[8 +: CH_W];
            end else begin
                if (in_inc)  in_cnt  <= in_nxt;
                if (out_inc) out_cnt <= out_nxt;
            end
        end
    end

    assign fb_addr_out   = base_l + ADDR_W'(out_cnt);
    assign isp_int       = irq_en & (done | err);
    assign ahb.HREADYOUT = 1'b1;

    always_comb begin
        ahb.HRDATA = '0;
        if (rd_en) begin
            if (is_ctrl) begin
                ahb.HRDATA[1]           = bypass_r;
                ahb.HRDATA[3]           = irq_en;
                ahb.HRDATA[7:4]         = bayer_r;
                ahb.HRDATA[8 +: CH_W]   = ch_r;
            end else if (is_stat) begin
                ahb.HRDATA[1:0]   = state;
                ahb.HRDATA[8]     = done;
                ahb.HRDATA[9]     = err;
                ahb.HRDATA[10]    = to_flag;
                ahb.HRDATA[15:12] = 4'(last_ch);
            end else if (is_cnt) begin
                ahb.HRDATA = 32'(out_cnt);
            end else if (ch_valid) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ch_word[9:1] == 9'(c)) begin
                        if (ch_word[0]) ahb.HRDATA = 32'(ch_base[c]);
                        else            ahb.HRDATA = 32'(ch_h[c]) | (32'(ch_v[c]) << 16);
                    end
                end
            end
        end
    end
endmodule
